// File: rtl/iommu_pkg.sv
// iommu_pkg: shared IOMMU definitions used by the memory read arbiter.
//   - requester index constants for the four table walkers
//   - mem_rd_state_e: read-arbiter FSM states
//   - MEM_RD_MAX_BEATS: longest context fetch (extended DC, 8 doublewords)
//   - MEM_RD_PLEN: physical address width of the platform
package iommu_pkg;

  localparam int MEM_RD_PLEN      = 56;
  localparam int MEM_RD_MAX_BEATS = 8;

  localparam int MEM_RD_DDT = 0;
  localparam int MEM_RD_PDT = 1;
  localparam int MEM_RD_MSI = 2;
  localparam int MEM_RD_PTW = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN,
    ERR_RESP
  } mem_rd_state_e;

endpackage

// File: rtl/iommu_rr_arb.sv
// iommu_rr_arb: combinational round-robin picker.
//   req  : request vector
//   ptr  : index with highest priority this cycle
//   gnt  : one-hot pick (zero when nothing requests)
//   idx  : index of the pick
//   any  : at least one request present
module iommu_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan from ptr upward, wrapping, and take the first requester found.
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/iommu_mem_rd_arb.sv
// iommu_mem_rd_arb: shares the IOMMU's single 64-bit memory read channel
// between the DDT walker, PDT walker, MSI PTE fetch and PTW.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   req_i/addr_i/len_i   : per-requester read request (held until gnt_o)
//   gnt_o                : one-hot single-cycle grant, request captured on it
//   rvalid_o/rdata_o     : beat steered to the owner (data shared)
//   rlast_o/err_o        : owner's last beat / access fault on this beat
//   mem_req_o/addr/len   : address phase towards the bus master (len = beats-1)
//   mem_gnt_i            : address-phase ready
//   mem_rvalid_i/rdata/rlast/rerr : returned beats, no backpressure
module iommu_mem_rd_arb
  import iommu_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = MEM_RD_PLEN,
  parameter int MAX_BEATS = MEM_RD_MAX_BEATS
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*4-1:0]      len_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rvalid_o,
  output logic [63:0]             rdata_o,
  output logic                    rlast_o,
  output logic                    err_o,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [7:0]              mem_len_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [63:0]             mem_rdata_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rerr_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  mem_rd_state_e     state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [3:0]        len_q;
  logic [3:0]        cnt;
  logic              err_q;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic [ADDR_W-1:0] pick_addr;
  logic [3:0]        pick_len;
  logic              pick_bad;
  logic              beat_last;
  logic              beat_early;

  // A request is refused when misaligned, of illegal length, or when the
  // burst runs past the end of its 4 KiB page (sum kept at 13 bits).
  function automatic logic req_bad(input logic [11:0] page_off, input logic [3:0] len);
    logic [12:0] end_off;
    end_off = {1'b0, page_off} + {6'b0, len, 3'b0};
    return (page_off[2:0] != 3'b0) || (len == 4'd0) ||
           (32'(len) > MAX_BEATS) || (end_off > 13'd4096);
  endfunction

  iommu_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req (req_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_addr  = addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign pick_len   = len_i[int'(pick_idx)*4 +: 4];
  assign pick_bad   = req_bad(pick_addr[11:0], pick_len);
  assign beat_last  = (cnt == len_q - 4'd1);
  // Memory ended the burst before the requester got all its beats.
  assign beat_early = mem_rlast_i && !beat_last;

  // Outputs are forced to zero while reset is held so a stray beat or a
  // request arriving during reset is never seen by the walkers.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    rlast_o  = 1'b0;
    err_o    = 1'b0;
    if (!rst_i) begin
      unique case (state)
        IDLE: gnt_o = pick_gnt;
        DATA: begin
          if (mem_rvalid_i) begin
            rvalid_o[owner] = 1'b1;
            rdata_o         = mem_rdata_i;
            rlast_o         = beat_last || mem_rlast_i;
            err_o           = mem_rerr_i || err_q || beat_early;
          end
        end
        ERR_RESP: begin
          rvalid_o[owner] = 1'b1;
          rlast_o         = 1'b1;
          err_o           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      len_q      <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_len_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            owner <= pick_idx;
            len_q <= pick_len;
            ptr   <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
            if (pick_bad) begin
              state <= ERR_RESP;
            end else begin
              state      <= ADDR;
              mem_req_o  <= 1'b1;
              mem_addr_o <= pick_addr;
              mem_len_o  <= {4'b0, pick_len - 4'd1};
            end
          end
        end
        ADDR: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid_i) begin
            cnt <= cnt + 4'd1;
            if (beat_last || mem_rlast_i) begin
              err_q <= 1'b0;
              // Requester satisfied but memory still sending: swallow the rest.
              state <= (beat_last && !mem_rlast_i) ? DRAIN : IDLE;
            end else if (mem_rerr_i) begin
              err_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (mem_rvalid_i && mem_rlast_i) state <= IDLE;
        end
        ERR_RESP: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iommu_mem_rd_arb.sv
// Directed bench for iommu_mem_rd_arb: per-cycle vector table plus
// hand-written sequences for reset values and a delayed 8-beat read.
module tb_iommu_mem_rd_arb;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 56;

  logic                    clk_i;
  logic                    rst_i;
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*ADDR_W-1:0] addr_i;
  logic [N_REQ*4-1:0]      len_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [63:0]             rdata_o;
  logic                    rlast_o;
  logic                    err_o;
  logic                    mem_req_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [7:0]              mem_len_o;
  logic                    mem_gnt_i;
  logic                    mem_rvalid_i;
  logic [63:0]             mem_rdata_i;
  logic                    mem_rlast_i;
  logic                    mem_rerr_i;

  iommu_mem_rd_arb #(
    .N_REQ     (N_REQ),
    .ADDR_W    (ADDR_W),
    .MAX_BEATS (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .len_i        (len_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .rlast_o      (rlast_o),
    .err_o        (err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_len_o    (mem_len_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rlast_i  (mem_rlast_i),
    .mem_rerr_i   (mem_rerr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [31:0] addr;
    logic [3:0] len;
    logic       mg, rv, rl, re;
    logic [7:0] rd;
    logic [3:0] egnt, ervalid;
    logic       erlast, eerr, emreq;
    logic [7:0] emlen, erd;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t v(input logic rst, input logic [3:0] req, input logic [31:0] addr,
                             input logic [3:0] len, input logic mg, input logic rv, input logic rl,
                             input logic re, input logic [7:0] rd, input logic [3:0] egnt,
                             input logic [3:0] ervalid, input logic erlast, input logic eerr,
                             input logic emreq, input logic [7:0] emlen, input logic [7:0] erd);
    vec_t r;
    r.rst = rst; r.req = req; r.addr = addr; r.len = len;
    r.mg = mg; r.rv = rv; r.rl = rl; r.re = re; r.rd = rd;
    r.egnt = egnt; r.ervalid = ervalid; r.erlast = erlast; r.eerr = eerr;
    r.emreq = emreq; r.emlen = emlen; r.erd = erd;
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] req, input logic [31:0] addr,
                       input logic [3:0] len, input logic mg, input logic rv, input logic rl,
                       input logic re, input logic [7:0] rd);
    rst_i        = rst;
    req_i        = req;
    addr_i       = {N_REQ{24'h0, addr}};
    len_i        = {N_REQ{len}};
    mem_gnt_i    = mg;
    mem_rvalid_i = rv;
    mem_rlast_i  = rl;
    mem_rerr_i   = re;
    mem_rdata_i  = {8{rd}};
  endtask

  localparam logic [31:0] A = 32'h8000_1000;

  initial begin
    drive(1'b1, 4'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);

    // rst req addr len mg rv rl re rd | gnt rvalid rlast err mreq mlen rdata
    // reset
    vecs.push_back(v(1, 4'b0000, 0, 0, 0,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(1, 4'b0000, 0, 0, 0,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    // single read, 4 beats; stray beat in ADDR ignored
    vecs.push_back(v(0, 4'b0001, A, 4, 0,0,0,0, 8'h00, 4'b0001, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, A, 4, 0,1,0,0, 8'hee, 4'b0000, 4'b0000, 0,0,1, 3, 8'h00));
    vecs.push_back(v(0, 4'b0000, A, 4, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 3, 8'h00));
    vecs.push_back(v(0, 4'b0000, A, 4, 0,1,0,0, 8'h11, 4'b0000, 4'b0001, 0,0,0, 0, 8'h11));
    vecs.push_back(v(0, 4'b0000, A, 4, 0,1,0,0, 8'h22, 4'b0000, 4'b0001, 0,0,0, 0, 8'h22));
    vecs.push_back(v(0, 4'b0000, A, 4, 0,1,0,0, 8'h33, 4'b0000, 4'b0001, 0,0,0, 0, 8'h33));
    vecs.push_back(v(0, 4'b0000, A, 4, 0,1,1,0, 8'h44, 4'b0000, 4'b0001, 1,0,0, 0, 8'h44));
    // contention after reset: 0, then 2, then 0 again (ptr wraps)
    vecs.push_back(v(1, 4'b0000, 0, 0, 0,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0101, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0001, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0100, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0000, 4'b0001, 1,1,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0100, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0100, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0101, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0000, 4'b0100, 1,1,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0101, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0001, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0000, 4'b0001, 1,1,0, 0, 8'h00));
    // request checks on requester 1
    vecs.push_back(v(0, 4'b0010, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0010, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80001004, 2, 0,0,0,0, 8'h00, 4'b0000, 4'b0010, 1,1,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0010, 32'h80000FF8, 2, 0,0,0,0, 8'h00, 4'b0010, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80000FF8, 2, 0,0,0,0, 8'h00, 4'b0000, 4'b0010, 1,1,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0010, A, 0, 0,0,0,0, 8'h00, 4'b0010, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, A, 0, 0,0,0,0, 8'h00, 4'b0000, 4'b0010, 1,1,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0010, A, 9, 0,0,0,0, 8'h00, 4'b0010, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, A, 9, 0,0,0,0, 8'h00, 4'b0000, 4'b0010, 1,1,0, 0, 8'h00));
    // burst ending exactly on the page boundary is legal
    vecs.push_back(v(0, 4'b0010, 32'h80000FF0, 2, 0,0,0,0, 8'h00, 4'b0010, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80000FF0, 2, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 1, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80000FF0, 2, 0,1,0,0, 8'h55, 4'b0000, 4'b0010, 0,0,0, 0, 8'h55));
    vecs.push_back(v(0, 4'b0000, 32'h80000FF0, 2, 0,1,1,0, 8'h66, 4'b0000, 4'b0010, 1,0,0, 0, 8'h66));
    // bus error on beat 2 of 4 stays sticky
    vecs.push_back(v(0, 4'b0100, 32'h80002000, 4, 0,0,0,0, 8'h00, 4'b0100, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80002000, 4, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 3, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80002000, 4, 0,1,0,0, 8'h01, 4'b0000, 4'b0100, 0,0,0, 0, 8'h01));
    vecs.push_back(v(0, 4'b0000, 32'h80002000, 4, 0,1,0,1, 8'h02, 4'b0000, 4'b0100, 0,1,0, 0, 8'h02));
    vecs.push_back(v(0, 4'b0000, 32'h80002000, 4, 0,1,0,0, 8'h03, 4'b0000, 4'b0100, 0,1,0, 0, 8'h03));
    vecs.push_back(v(0, 4'b0000, 32'h80002000, 4, 0,1,1,0, 8'h04, 4'b0000, 4'b0100, 1,1,0, 0, 8'h04));
    // early last: len 8, memory stops after 2
    vecs.push_back(v(0, 4'b1000, 32'h80003000, 8, 0,0,0,0, 8'h00, 4'b1000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80003000, 8, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 7, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80003000, 8, 0,1,0,0, 8'ha1, 4'b0000, 4'b1000, 0,0,0, 0, 8'ha1));
    vecs.push_back(v(0, 4'b0000, 32'h80003000, 8, 0,1,1,0, 8'ha2, 4'b0000, 4'b1000, 1,1,0, 0, 8'ha2));
    // late last: len 1, memory sends 2
    vecs.push_back(v(0, 4'b0001, 32'h80004000, 1, 0,0,0,0, 8'h00, 4'b0001, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80004000, 1, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80004000, 1, 0,1,0,0, 8'hb1, 4'b0000, 4'b0001, 1,0,0, 0, 8'hb1));
    vecs.push_back(v(0, 4'b0000, 32'h80004000, 1, 0,1,1,0, 8'hb2, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    // reset mid-DATA, stray beats, then requester 3
    vecs.push_back(v(0, 4'b0010, 32'h80005000, 4, 0,0,0,0, 8'h00, 4'b0010, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80005000, 4, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 3, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80005000, 4, 0,1,0,0, 8'hc1, 4'b0000, 4'b0010, 0,0,0, 0, 8'hc1));
    vecs.push_back(v(1, 4'b0000, 32'h80005000, 4, 0,1,0,0, 8'hc2, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80005000, 4, 0,1,0,0, 8'hc3, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80005000, 4, 0,1,1,0, 8'hc4, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b1000, 32'h80006000, 2, 0,0,0,0, 8'h00, 4'b1000, 4'b0000, 0,0,0, 0, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80006000, 2, 1,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,1, 1, 8'h00));
    vecs.push_back(v(0, 4'b0000, 32'h80006000, 2, 0,1,0,0, 8'hd1, 4'b0000, 4'b1000, 0,0,0, 0, 8'hd1));
    vecs.push_back(v(0, 4'b0000, 32'h80006000, 2, 0,1,1,0, 8'hd2, 4'b0000, 4'b1000, 1,0,0, 0, 8'hd2));
    vecs.push_back(v(0, 4'b0000, 0, 0, 0,0,0,0, 8'h00, 4'b0000, 4'b0000, 0,0,0, 0, 8'h00));

    foreach (vecs[k]) begin
      @(posedge clk_i);
      #1;
      drive(vecs[k].rst, vecs[k].req, vecs[k].addr, vecs[k].len,
            vecs[k].mg, vecs[k].rv, vecs[k].rl, vecs[k].re, vecs[k].rd);
      #2;
      chk("gnt",     k, 64'(gnt_o),     64'(vecs[k].egnt));
      chk("rvalid",  k, 64'(rvalid_o),  64'(vecs[k].ervalid));
      chk("rlast",   k, 64'(rlast_o),   64'(vecs[k].erlast));
      chk("err",     k, 64'(err_o),     64'(vecs[k].eerr));
      chk("mem_req", k, 64'(mem_req_o), 64'(vecs[k].emreq));
      if (vecs[k].emreq) begin
        chk("mem_len",  k, 64'(mem_len_o),  64'(vecs[k].emlen));
        chk("mem_addr", k, 64'(mem_addr_o), 64'(vecs[k].addr));
      end
      if (vecs[k].ervalid != 4'b0)
        chk("rdata", k, rdata_o, {8{vecs[k].erd}});
    end

    // Registered address-phase outputs return to zero on reset.
    @(posedge clk_i); #1;
    drive(1'b1, 4'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
    @(posedge clk_i); #1;
    drive(1'b0, 4'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
    #2;
    chk("rst_mem_addr", 100, 64'(mem_addr_o), 64'h0);
    chk("rst_mem_len",  100, 64'(mem_len_o),  64'h0);
    chk("rst_mem_req",  100, 64'(mem_req_o),  64'h0);

    // 8-beat extended-DC read on requester 2 with a slow address grant.
    @(posedge clk_i); #1;
    drive(1'b0, 4'b0100, 32'h80007000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
    #2;
    chk("dc8_gnt", 200, 64'(gnt_o), 64'h4);
    for (int w = 0; w < 3; w++) begin
      @(posedge clk_i); #1;
      drive(1'b0, 4'b0000, 32'h80007000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
      #2;
      chk("dc8_mreq_hold", 201 + w, 64'({mem_req_o, mem_len_o}), 64'({1'b1, 8'd7}));
    end
    @(posedge clk_i); #1;
    drive(1'b0, 4'b0000, 32'h80007000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0);
    for (int b = 0; b < 8; b++) begin
      @(posedge clk_i); #1;
      drive(1'b0, 4'b0000, 32'h80007000, 4'd8, 1'b0, 1'b1, (b == 7), 1'b0, 8'(8'h70 + b));
      #2;
      chk("dc8_rvalid", 210 + b, 64'(rvalid_o), 64'h4);
      chk("dc8_rlast",  210 + b, 64'(rlast_o),  64'(b == 7));
      chk("dc8_err",    210 + b, 64'(err_o),    64'h0);
      chk("dc8_rdata",  210 + b, rdata_o, {8{8'(8'h70 + b)}});
    end
    // Next grant lands in the cycle right after the last beat.
    @(posedge clk_i); #1;
    drive(1'b0, 4'b0001, 32'h80008000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
    #2;
    chk("b2b_gnt", 220, 64'(gnt_o), 64'h1);
    @(posedge clk_i); #1;
    drive(1'b0, 4'b0000, 32'h80008000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0);
    #2;
    chk("b2b_mreq", 221, 64'({mem_req_o, mem_len_o}), 64'({1'b1, 8'd0}));
    @(posedge clk_i); #1;
    drive(1'b0, 4'b0000, 32'h80008000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5a);
    #2;
    chk("b2b_beat", 222, 64'({rvalid_o, rlast_o, err_o}), 64'({4'b0001, 1'b1, 1'b0}));

    @(posedge clk_i); #1;
    drive(1'b0, 4'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
